sysid_ext_regs: RTL and testbench
=================================

# sysid_ext_regs

Parametrised successor to the Qsys system-ID slave for the niosII_system. It exposes a small Avalon-MM register bank with:
- Build identity words: system ID, timestamp and capability word.
- Two lockable scratch registers.
- An optional free-running uptime counter with an atomic high-word snapshot.

Reads are registered (fixed latency 1, `readdatavalid`). Software uses the block for build identification, boot-time sanity checks and coarse timekeeping.

## Interface
Parameters:
- `ID`, 32'h5894A73C, value returned at word 0.
- `TIMESTAMP`, 32'h0, build timestamp returned at word 1.
- `CNT_W`, 64, uptime counter width; legal range 33..64.

Ports:
- `clock`  in  1  sole clock; all logic rising-edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `address`  in  3  word address.
- `read`  in  1  read strobe, one cycle per transaction.
- `write`  in  1  write strobe, one cycle per transaction.
- `writedata`  in  32  write data.
- `byteenable`  in  4  byte lanes for `writedata`.
- `readdata`  out  32  registered read data.
- `readdatavalid`  out  1  one-cycle pulse, one cycle after `read`.

## Operation
Word map:
- 0 `SYSID`: RO, returns `ID`.
- 1 `TIMESTAMP`: RO, returns `TIMESTAMP`.
- 2 `CAPS`: RO.
  - bit0: uptime counter present.
  - bit1: lock state.
  - bits[15:8]: `CNT_W`.
  - bits[31:16]: 16'h0002.
  - All other bits read 0.
- 3 `SCRATCH0` and 4 `SCRATCH1`: RW.
  - Each byte is written only where `byteenable[i]`=1.
  - Writes are ignored while locked.
- 5 `UPTIME_LO`: RO.
  - Returns `counter[31:0]`.
  - The same read also copies `counter[CNT_W-1:32]`, zero-extended, into `hi_shadow`.
- 6 `UPTIME_HI`: RO, returns `hi_shadow`. It does not latch anything.
- 7 `CONTROL`: writes are honoured only when `byteenable[0]`=1.
  - bit0 `LOCK`: writing 1 sets the lock. The lock is sticky until reset; writing 0 has no effect.
  - bit1 `CLR`: writing 1 zeroes the counter. Self-clearing; reads as 0.
  - Reads return {30'b0, CLR=0, LOCK}.

Uptime counter:
- Increments by 1 every clock.
- Wraps from 2^CNT_W−1 to 0 with no flag.
- CLR has priority over increment: the counter is 0 after the write edge, then counts 1, 2, …

Unmapped conditions:
- `read` and `write` asserted together: the write takes effect; `readdata` returns the pre-write value of the addressed register.
- Writes to RO words (0, 1, 2, 5, 6) are ignored.

Reset (while `reset_n`=0 at an edge), everything clears:
- `readdata`=0, `readdatavalid`=0.
- SCRATCH0/1=0, LOCK=0.
- counter=0, `hi_shadow`=0.
- A read issued in the reset cycle produces no `readdatavalid`.

## Timing
- Read latency is exactly 1. `read` at edge N gives `readdatavalid`=1 and `readdata` valid in cycle N+1. `readdatavalid` returns to 0 at N+2 unless another read was issued.
- Back-to-back reads on consecutive cycles are supported. They produce consecutive valid pulses.
- `readdata` holds its last value while `readdatavalid`=0.
- `UPTIME_LO` returns the counter value present at the read-sampling edge N. `hi_shadow` is captured from that same counter value.
  - This guarantees a consistent 64-bit pair when software reads LO then HI, including across a carry from bit 31 to bit 32.
- Writes take effect at the sampling edge and are visible to a read issued on the next cycle.
- No wait states. `waitrequest` is not implemented.

## Configuration
- `SYSID_UPTIME_EN` defined: the counter and `hi_shadow` are built; `CAPS[0]`=1.
- `SYSID_UPTIME_EN` undefined:
  - The counter and `hi_shadow` are removed.
  - Words 5 and 6 read 0.
  - `CLR` is ignored.
  - `CAPS[0]`=0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read words 0, 1 and 2 with the default parameters (define on). Expect:
  - 0x5894A73C, then 0x00000000, then 0x00024001.
  - `readdatavalid` exactly one cycle after each read.
- Write 0xDEADBEEF with `byteenable`=4'b0101 to SCRATCH0 (after a previous 0), then read it back. Expect 0x00AD00EF.
- Write `CONTROL`=1, then write 0x12345678 to SCRATCH1, then read SCRATCH1 and `CAPS`. Expect:
  - SCRATCH1 = 0.
  - `CAPS[1]`=1.
  - LOCK survives a CLR write and clears only after `reset_n` is held low for 1 cycle.
- Write CLR, wait exactly 5 cycles after the write edge, then read `UPTIME_LO`. Expect 5 (counter sampled at that read edge).
- Force the counter to 0x0000_0000_FFFF_FFFF, read LO, then read HI on the next cycle. Expect 0xFFFFFFFF, then 0x00000000 (not 1).
- Build without `SYSID_UPTIME_EN` and read words 5, 6 and 2. Expect 0, 0 and 0x00024000.

Source files
------------

// File: rtl/sysid_ext_regs.sv
// sysid_ext_regs: Avalon-MM system-ID register bank with build identity words,
// two lockable scratch registers and an optional uptime counter.
// Optional feature macro: SYSID_UPTIME_EN builds the uptime counter and the
// atomic high-word snapshot; when undefined, words 5/6 read 0 and CLR is ignored.
module sysid_ext_regs #(
  parameter logic [31:0] ID        = 32'h5894A73C,
  parameter logic [31:0] TIMESTAMP = 32'h0,
  parameter int unsigned CNT_W     = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  typedef enum logic [2:0] {
    W_SYSID     = 3'd0,
    W_TIMESTAMP = 3'd1,
    W_CAPS      = 3'd2,
    W_SCRATCH0  = 3'd3,
    W_SCRATCH1  = 3'd4,
    W_UPTIME_LO = 3'd5,
    W_UPTIME_HI = 3'd6,
    W_CONTROL   = 3'd7
  } word_e;

  localparam logic [7:0] CNT_W_BYTE = 8'(CNT_W);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  logic [31:0] scratch0;
  logic [31:0] scratch1;
  logic        lock;
  logic [31:0] caps;
  logic [31:0] rd_mux;
  logic        ctl_wr;

  assign ctl_wr = write && (address == W_CONTROL) && byteenable[0];
  assign caps   = {16'h0002, CNT_W_BYTE, 6'b0, lock, UPTIME_PRESENT};

`ifdef SYSID_UPTIME_EN
  logic [CNT_W-1:0] counter;
  logic [31:0]      hi_shadow;
  logic [31:0]      hi_ext;
  logic             clr;

  assign clr = ctl_wr && writedata[1];

  // Zero-extend the counter bits above 31 into a full 32-bit word
  always_comb begin
    hi_ext = '0;
    hi_ext[CNT_W-33:0] = counter[CNT_W-1:32];
  end

  // Free-running uptime counter; CLR wins over increment; LO read snapshots the high word
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      counter   <= '0;
      hi_shadow <= '0;
    end else begin
      if (clr) counter <= '0;
      else     counter <= counter + 1'b1;
      if (read && (address == W_UPTIME_LO)) hi_shadow <= hi_ext;
    end
  end
`endif

  // Read-data select for the addressed word (pre-write values)
  always_comb begin
    rd_mux = '0;
    case (address)
      W_SYSID:     rd_mux = ID;
      W_TIMESTAMP: rd_mux = TIMESTAMP;
      W_CAPS:      rd_mux = caps;
      W_SCRATCH0:  rd_mux = scratch0;
      W_SCRATCH1:  rd_mux = scratch1;
`ifdef SYSID_UPTIME_EN
      W_UPTIME_LO: rd_mux = counter[31:0];
      W_UPTIME_HI: rd_mux = hi_shadow;
`else
      W_UPTIME_LO: rd_mux = '0;
      W_UPTIME_HI: rd_mux = '0;
`endif
      W_CONTROL:   rd_mux = {30'b0, 1'b0, lock};
      default:     rd_mux = '0;
    endcase
  end

  // Registered read port with fixed one-cycle latency
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

  // Scratch registers with byte-lane writes, and the sticky lock bit
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch0 <= '0;
      scratch1 <= '0;
      lock     <= 1'b0;
    end else begin
      if (write && !lock && (address == W_SCRATCH0)) begin
        for (int unsigned i = 0; i < 4; i++)
          if (byteenable[i]) scratch0[8*i +: 8] <= writedata[8*i +: 8];
      end
      if (write && !lock && (address == W_SCRATCH1)) begin
        for (int unsigned i = 0; i < 4; i++)
          if (byteenable[i]) scratch1[8*i +: 8] <= writedata[8*i +: 8];
      end
      if (ctl_wr && writedata[0]) lock <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_ext_regs.sv
// Self-checking bench for sysid_ext_regs: expected read data is queued when a
// read is driven and compared when readdatavalid appears.
module tb_sysid_ext_regs;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int unsigned n_checks   = 0;
  int unsigned n_failures = 0;
  logic [31:0] sb_q[$];

  localparam logic [31:0] EXP_ID = 32'h5894A73C;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] EXP_CAPS = 32'h00024001;
`else
  localparam logic [31:0] EXP_CAPS = 32'h00024000;
`endif

  sysid_ext_regs #(
    .ID        (32'h5894A73C),
    .TIMESTAMP (32'h0),
    .CNT_W     (64)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: readdatavalid must follow a non-reset read by one edge; data comes from the scoreboard
  always @(posedge clock) begin
    logic exp_v;
    exp_v = read && reset_n;
    #1;
    check("rdv", {31'b0, readdatavalid}, {31'b0, exp_v});
    if (readdatavalid === 1'b1 && sb_q.size() > 0)
      check("rdata", readdata, sb_q.pop_front());
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp);
    address = a;
    read    = 1'b1;
    sb_q.push_back(exp);
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    write      = 1'b1;
    writedata  = d;
    byteenable = be;
    @(negedge clock);
    write = 1'b0;
  endtask

  // Write and read the same word in one cycle: read returns the pre-write value
  task automatic do_rw(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp);
    address    = a;
    write      = 1'b1;
    read       = 1'b1;
    writedata  = d;
    byteenable = be;
    sb_q.push_back(exp);
    @(negedge clock);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic apply_reset(input int unsigned cycles, input logic rd_during);
    reset_n = 1'b0;
    read    = rd_during;
    address = 3'd0;
    repeat (cycles) @(negedge clock);
    read    = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=0x%08h expected=0x%08h", 32'h0, 32'h1);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0;
    @(negedge clock);
    apply_reset(2, 1'b1);
    check("reset_rdata", readdata, 32'h0);

    // Identity words back-to-back
    do_read(3'd0, EXP_ID);
    do_read(3'd1, 32'h0);
    do_read(3'd2, EXP_CAPS);
    idle(1);

    // Byte-lane writes to scratch registers
    do_write(3'd3, 32'hDEADBEEF, 4'b0101);
    do_read(3'd3, 32'h00AD00EF);
    do_write(3'd4, 32'h12345678, 4'b1100);
    do_read(3'd4, 32'h12340000);
    do_rw(3'd3, 32'hFFFFFFFF, 4'b1111, 32'h00AD00EF);
    do_read(3'd3, 32'hFFFFFFFF);

    // Writes to RO words are ignored
    do_write(3'd0, 32'h0, 4'b1111);
    do_write(3'd2, 32'hFFFFFFFF, 4'b1111);
    do_read(3'd0, EXP_ID);
    do_read(3'd2, EXP_CAPS);

    // CONTROL write without byteenable[0] is ignored
    do_write(3'd7, 32'h1, 4'b1110);
    do_read(3'd7, 32'h0);

`ifdef SYSID_UPTIME_EN
    // CLR then 5 idle edges: read samples counter value 5
    do_write(3'd7, 32'h2, 4'b0001);
    idle(5);
    do_read(3'd5, 32'd5);
    do_read(3'd6, 32'h0);
    // Carry across bit 31: HI must reflect the snapshot taken with LO
    force dut.counter = 64'h0000_0000_FFFF_FFFF;
    do_read(3'd5, 32'hFFFFFFFF);
    release dut.counter;
    do_read(3'd6, 32'h0);
`else
    do_write(3'd7, 32'h2, 4'b0001);
    idle(3);
    do_read(3'd5, 32'h0);
    do_read(3'd6, 32'h0);
`endif

    // Lock: scratch writes ignored, lock is sticky through CLR
    do_write(3'd7, 32'h1, 4'b0001);
    do_write(3'd4, 32'h12345678, 4'b1111);
    do_read(3'd4, 32'h12340000);
    do_read(3'd2, EXP_CAPS | 32'h2);
    do_write(3'd7, 32'h2, 4'b0001);
    do_read(3'd7, 32'h1);
    do_write(3'd7, 32'h0, 4'b0001);
    do_read(3'd7, 32'h1);
    idle(1);

    // One-cycle reset with a read in flight clears everything
    apply_reset(1, 1'b1);
    check("reset2_rdata", readdata, 32'h0);
    do_read(3'd7, 32'h0);
    do_read(3'd3, 32'h0);
    do_read(3'd4, 32'h0);
    do_read(3'd2, EXP_CAPS);
    do_write(3'd4, 32'hA5A5A5A5, 4'b1111);
    do_read(3'd4, 32'hA5A5A5A5);
    idle(2);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
